biassram_r: RTL and testbench

- Read-side sequencer for bias SRAM_0; the counterpart to the bias write path.
- On bias_rd1st_start it prefetches output-channel group 0 into the PE bias registers, then fetches each following group on request.
- It owns the read port signals of bias SRAM_0 (cen/wen/addr) and emits a valid/data/index stream to the PE array.
- It pulses a layer-done when all BIAS_ST_LENGTH words have been delivered, then wraps the group pointer to 0.

---
 rtl/biassram_r.sv | 147 ++++++++++++++
 tb/tb_biassram_r.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biassram_r.sv
// Read-side sequencer for bias SRAM_0.
// Prefetches output-channel group 0 on bias_rd1st_start, then fetches each
// following group on bias_next_req. Drives the SRAM read port and presents a
// valid/data/index stream one cycle after each read. The group base pointer
// wraps to 0 after the last group of the layer, which also raises bias_layer_done.
module biassram_r #(
  parameter int BIAS_ST_LENGTH = 64,
  parameter int GROUP_BIAS     = 8,
  parameter int ADDR_CNT_BITS  = 9,
  parameter int BIAS_SRAM_WLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bias_rd1st_start,
  output logic                      bias_rd1st_busy,
  output logic                      bias_rd1st_done,
  input  logic                      bias_next_req,
  output logic                      bias_grp_busy,
  output logic                      bias_grp_done,
  output logic                      bias_layer_done,
  output logic                      cen_biasr_0,
  output logic                      wen_biasr_0,
  output logic [ADDR_CNT_BITS-1:0]  addr_biasr_0,
  input  logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0,
  output logic                      bias_valid_dout,
  output logic [BIAS_SRAM_WLEN-1:0] bias_data_dout,
  output logic [ADDR_CNT_BITS-1:0]  bias_idx_dout
);

  localparam int KW = $clog2(GROUP_BIAS);
  localparam logic [KW-1:0]          K_LAST    = KW'(GROUP_BIAS - 1);
  localparam logic [ADDR_CNT_BITS:0] GRP_INC   = (ADDR_CNT_BITS + 1)'(GROUP_BIAS);
  localparam logic [ADDR_CNT_BITS:0] LAYER_END = (ADDR_CNT_BITS + 1)'(BIAS_ST_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_CNT_BITS-1:0] base_q, base_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     first_q, first_d;
  logic                     valid_q, valid_d;
  logic [ADDR_CNT_BITS-1:0] idx_q, idx_d;
  logic                     rd1st_done_q, rd1st_done_d;
  logic                     grp_done_q, grp_done_d;
  logic                     layer_done_q, layer_done_d;

  // One extra bit so a layer filling the whole address space still detects its end.
  logic [ADDR_CNT_BITS:0]   base_inc;
  logic                     wrap;

  assign base_inc = {1'b0, base_q} + GRP_INC;
  assign wrap     = (base_inc == LAYER_END);

  // State register plus registered output stage; everything returns to idle on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      k_q          <= '0;
      first_q      <= 1'b0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      rd1st_done_q <= 1'b0;
      grp_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      first_q      <= first_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      rd1st_done_q <= rd1st_done_d;
      grp_done_q   <= grp_done_d;
      layer_done_q <= layer_done_d;
    end
  end

  // Next-state logic: start always restarts from group 0 and wins over next_req.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (bias_rd1st_start) begin
          state_d = ST_RD;
          base_d  = '0;
          k_d     = '0;
          first_d = 1'b1;
        end
      end
      ST_RD: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WAIT;
        base_d  = wrap ? '0 : base_inc[ADDR_CNT_BITS-1:0];
      end
      ST_WAIT: begin
        if (bias_rd1st_start) begin
          state_d = ST_RD;
          base_d  = '0;
          k_d     = '0;
          first_d = 1'b1;
        end else if (bias_next_req) begin
          state_d = ST_RD;
          k_d     = '0;
          first_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: SRAM port, busy flags, and inputs to the registered output stage.
  always_comb begin
    cen_biasr_0     = (state_q != ST_RD);
    wen_biasr_0     = 1'b1;
    addr_biasr_0    = (state_q == ST_RD) ? (base_q + ADDR_CNT_BITS'(k_q)) : '0;
    bias_rd1st_busy = ((state_q == ST_RD) || (state_q == ST_DRAIN)) && first_q;
    bias_grp_busy   = ((state_q == ST_RD) || (state_q == ST_DRAIN)) && !first_q;
    valid_d         = ~cen_biasr_0;
    idx_d           = addr_biasr_0;
    rd1st_done_d    = (state_q == ST_DRAIN) && first_q;
    grp_done_d      = (state_q == ST_DRAIN) && !first_q;
    layer_done_d    = (state_q == ST_DRAIN) && wrap;
  end

  assign bias_valid_dout = valid_q;
  assign bias_idx_dout   = idx_q;
  assign bias_data_dout  = dout_biasr_0;
  assign bias_rd1st_done = rd1st_done_q;
  assign bias_grp_done   = grp_done_q;
  assign bias_layer_done = layer_done_q;

endmodule

// File: tb/tb_biassram_r.sv
// Bench for biassram_r: directed scenarios plus random request traffic, all
// checked against a transaction-level model that schedules the expected output
// timeline of each accepted group fetch.
module tb_biassram_r;
  localparam int L  = 16;
  localparam int G  = 4;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          next_req = 1'b0;
  logic          rd1st_busy, rd1st_done, grp_busy, grp_done, layer_done;
  logic          cen, wen, valid;
  logic [AW-1:0] addr, idx;
  logic [DW-1:0] dout = '0;
  logic [DW-1:0] data;

  biassram_r #(
    .BIAS_ST_LENGTH(L),
    .GROUP_BIAS(G),
    .ADDR_CNT_BITS(AW),
    .BIAS_SRAM_WLEN(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bias_rd1st_start(start),
    .bias_rd1st_busy(rd1st_busy),
    .bias_rd1st_done(rd1st_done),
    .bias_next_req(next_req),
    .bias_grp_busy(grp_busy),
    .bias_grp_done(grp_done),
    .bias_layer_done(layer_done),
    .cen_biasr_0(cen),
    .wen_biasr_0(wen),
    .addr_biasr_0(addr),
    .dout_biasr_0(dout),
    .bias_valid_dout(valid),
    .bias_data_dout(data),
    .bias_idx_dout(idx)
  );

  always #5 clk = ~clk;

  // SRAM model: mem[a] = 0x100 + a, one cycle read latency.
  initial forever begin
    @(posedge clk);
    if (!cen) dout <= 32'h100 + 32'(addr);
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs per future cycle (ring indexed by cycle number).
  typedef struct {
    bit cen_low;
    int addr;
    bit valid;
    int idx;
    bit b1, bg, d1, dg, ly, rst;
  } slot_t;

  slot_t sl[16];
  slot_t empty_s;
  bit    chk_en = 1'b0;
  int    busy_until = -1;
  bit    started = 1'b0;
  int    base_m = 0;

  // A fetch accepted in cycle c reads cycles c+1..c+G, delivers c+2..c+G+1,
  // is busy c+1..c+G+1 and signals completion at c+G+2.
  task automatic launch(input int c, input bit f);
    int b;
    b = base_m;
    for (int i = 0; i < G; i++) begin
      sl[(c + 1 + i) % 16].cen_low = 1'b1;
      sl[(c + 1 + i) % 16].addr    = b + i;
      sl[(c + 2 + i) % 16].valid   = 1'b1;
      sl[(c + 2 + i) % 16].idx     = b + i;
    end
    for (int i = 1; i <= G + 1; i++) begin
      sl[(c + i) % 16].b1 = f;
      sl[(c + i) % 16].bg = !f;
    end
    sl[(c + G + 2) % 16].d1 = f;
    sl[(c + G + 2) % 16].dg = !f;
    sl[(c + G + 2) % 16].ly = (b + G == L);
    base_m     = (b + G) % L;
    busy_until = c + G + 1;
    started    = 1'b1;
  endtask

  // Compare process: check this cycle's outputs, then fold in this cycle's inputs.
  initial begin
    slot_t s;
    forever begin
      @(negedge clk);
      s = sl[cyc % 16];
      sl[cyc % 16] = empty_s;
      if (chk_en) begin
        chk("wen", 32'(wen), 1);
        chk("cen", 32'(cen), s.cen_low ? 0 : 1);
        if (s.cen_low) chk("addr", 32'(addr), s.addr);
        chk("valid", 32'(valid), 32'(s.valid));
        if (s.valid) begin
          chk("idx", 32'(idx), s.idx);
          chk("data", data, 32'h100 + s.idx);
        end
        chk("rd1st_busy", 32'(rd1st_busy), 32'(s.b1));
        chk("grp_busy", 32'(grp_busy), 32'(s.bg));
        chk("rd1st_done", 32'(rd1st_done), 32'(s.d1));
        chk("grp_done", 32'(grp_done), 32'(s.dg));
        chk("layer_done", 32'(layer_done), 32'(s.ly));
        if (s.rst) begin
          chk("rst_addr", 32'(addr), 0);
          chk("rst_idx", 32'(idx), 0);
        end
      end
      if (reset) begin
        for (int i = 0; i < 16; i++) sl[i] = empty_s;
        busy_until = -1;
        started    = 1'b0;
        base_m     = 0;
        sl[(cyc + 1) % 16].rst = 1'b1;
        chk_en = 1'b1;
      end else if (start && cyc > busy_until) begin
        base_m = 0;
        launch(cyc, 1'b1);
      end else if (next_req && started && cyc > busy_until) begin
        launch(cyc, 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic pulse_start(output int t);
    t = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_next(output int t);
    t = cyc;
    next_req = 1'b1;
    tick(1);
    next_req = 1'b0;
  endtask

  task automatic wait_done(output int td);
    bit seen;
    seen = 1'b0;
    td = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (rd1st_done || grp_done) begin
        seen = 1'b1;
        td = cyc;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout cyc=%0d actual=none required=done_pulse", cyc);
    end
  endtask

  int t0, t1, td;

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_cen", 32'(cen), 1);
    chk("reset_valid", 32'(valid), 0);

    // First-group prefetch with hand-computed timing.
    pulse_start(t0);
    at_cycle(t0 + 1);
    chk("t1_cen", 32'(cen), 0);
    chk("t1_addr", 32'(addr), 0);
    at_cycle(t0 + 2);
    chk("t1_data0", data, 32'h100);
    chk("t1_idx0", 32'(idx), 0);
    at_cycle(t0 + 4);
    chk("t1_addr3", 32'(addr), 3);
    at_cycle(t0 + 5);
    chk("t1_data3", data, 32'h103);
    chk("t1_busy5", 32'(rd1st_busy), 1);
    at_cycle(t0 + 6);
    chk("t1_done", 32'(rd1st_done), 1);
    chk("t1_grpdone", 32'(grp_done), 0);
    tick(1);

    // Remaining groups of the layer, then wrap back to group 0.
    for (int g = 1; g <= 4; g++) begin
      pulse_next(t1);
      at_cycle(t1 + 2);
      chk("t2_first_word", data, 32'h100 + 32'((4 * g) % L));
      wait_done(td);
      chk("t2_grp_done", 32'(grp_done), 1);
      chk("t2_layer_done", 32'(layer_done), (g == 3) ? 1 : 0);
      tick(1);
    end

    // Request during RD is dropped; a later one fetches exactly one group.
    pulse_next(t1);
    tick(1);
    pulse_next(t1);
    wait_done(td);
    tick(2);
    pulse_next(t1);
    at_cycle(t1 + 1);
    chk("t3_addr", 32'(addr), 8);
    wait_done(td);
    tick(6);

    // next_req in IDLE does nothing; start beats next_req in WAIT at base 8.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    pulse_next(t1);
    tick(3);
    pulse_start(t1);
    wait_done(td);
    tick(1);
    pulse_next(t1);
    wait_done(td);
    tick(1);
    t1 = cyc;
    start = 1'b1;
    next_req = 1'b1;
    tick(1);
    start = 1'b0;
    next_req = 1'b0;
    at_cycle(t1 + 1);
    chk("t4_addr", 32'(addr), 0);
    at_cycle(t1 + 2);
    chk("t4_rd1st_busy", 32'(rd1st_busy), 1);
    chk("t4_grp_busy", 32'(grp_busy), 0);
    wait_done(td);
    tick(1);

    // Reset during the third RD cycle drops the rest of the group.
    pulse_start(t0);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    at_cycle(t0 + 4);
    chk("t5_cen", 32'(cen), 1);
    chk("t5_valid", 32'(valid), 0);
    chk("t5_busy", 32'(rd1st_busy), 0);
    tick(8);
    pulse_start(t1);
    at_cycle(t1 + 1);
    chk("t5_restart_addr", 32'(addr), 0);
    wait_done(td);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      next_req = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 80) == 0);
      tick(1);
    end
    start = 1'b0;
    next_req = 1'b0;
    reset = 1'b0;
    tick(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
